// File: rtl/morse_message_sequencer.sv
// Morse message sequencer: buffers UART bytes, upper-cases letters, and feeds
// morse_generator one character at a time with Morse-unit timed gaps between
// characters and words.
module morse_message_sequencer #(
  parameter int FIFO_DEPTH     = 16,
  parameter int MORSE_CYCLES   = 5000000,
  parameter int CHAR_GAP_UNITS = 3,
  parameter int WORD_GAP_UNITS = 7
) (
  input  logic                          clk_i,
  input  logic                          reset_i,
  input  logic [7:0]                    rx_data_i,
  input  logic                          rx_valid_i,
  output logic [7:0]                    gen_ascii_o,
  output logic                          gen_start_o,
  input  logic                          gen_done_i,
  output logic                          busy_o,
  output logic                          full_o,
  output logic                          overflow_o,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count_o
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  // Gap counter is sized for the longest silence (a full word gap).
  localparam int unsigned GAP_MAX = WORD_GAP_UNITS * MORSE_CYCLES;
  localparam int GW = (GAP_MAX < 2) ? 1 : $clog2(GAP_MAX + 1);
  localparam logic [GW-1:0] CHAR_LD = GW'(CHAR_GAP_UNITS * MORSE_CYCLES);
  // A separator only adds the extra word time; the char gap already elapsed.
  localparam logic [GW-1:0] WORD_LD = GW'((WORD_GAP_UNITS - CHAR_GAP_UNITS) * MORSE_CYCLES);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    START,
    WAIT_DONE,
    GAP
  } state_e;

  // ---------------------------------------------------------------- FIFO
  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          overflow_q, overflow_d;
  logic          push, pop;
  logic [7:0]    wr_byte;

  // ---------------------------------------------------------------- FSM
  state_e        state_q, state_d;
  logic [7:0]    char_q, char_d;
  logic [7:0]    ascii_q, ascii_d;
  logic [GW-1:0] gap_q, gap_d;
  logic          armed_q, armed_d;
  logic          start_q, start_d;
  logic          is_sep;

  assign full_o       = (count_q == CW'(FIFO_DEPTH));
  assign push         = rx_valid_i && !full_o;
  assign pop          = (state_q == IDLE) && (count_q != '0);
  assign is_sep       = (char_q == 8'h20) || (char_q == 8'h0A) || (char_q == 8'h0D);

  assign gen_ascii_o  = ascii_q;
  assign gen_start_o  = start_q;
  assign busy_o       = (count_q != '0) || (state_q != IDLE);
  assign overflow_o   = overflow_q;
  assign fifo_count_o = count_q;

  // Lowercase a..z folds to uppercase on the way in; everything else is kept.
  always_comb begin
    wr_byte = rx_data_i;
    if (rx_data_i >= 8'h61 && rx_data_i <= 8'h7A) wr_byte = rx_data_i - 8'h20;
  end

  // FIFO storage; no reset needed, occupancy is tracked by count_q.
  always_ff @(posedge clk_i) begin
    if (push) mem_q[wr_ptr_q] <= wr_byte;
  end

  // FIFO pointer, count and sticky overflow next-state.
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    // full_o is taken before the pop, so a push while full is lost even if a pop happens.
    if (rx_valid_i && full_o) overflow_d = 1'b1;
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Character sequencing FSM: next state and datapath updates.
  always_comb begin
    state_d = state_q;
    char_d  = char_q;
    ascii_d = ascii_q;
    gap_d   = gap_q;
    armed_d = armed_q;
    start_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (count_q != '0) begin
          char_d  = mem_q[rd_ptr_q];
          state_d = LOAD;
        end
      end
      LOAD: begin
        if (is_sep) begin
          gap_d   = WORD_LD;
          state_d = (WORD_LD == '0) ? IDLE : GAP;
        end else begin
          ascii_d = char_q;
          start_d = 1'b1;
          state_d = START;
        end
      end
      START: begin
        // Forget any done level seen so far; it belongs to the previous char.
        armed_d = 1'b0;
        state_d = WAIT_DONE;
      end
      WAIT_DONE: begin
        if (!gen_done_i) armed_d = 1'b1;
        if (armed_q && gen_done_i) begin
          gap_d   = CHAR_LD;
          state_d = (CHAR_LD == '0) ? IDLE : GAP;
        end
      end
      GAP: begin
        gap_d = gap_q - GW'(1);
        if (gap_q <= GW'(1)) begin
          gap_d   = '0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers; reset abandons any character in flight.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      state_q    <= IDLE;
      char_q     <= 8'h00;
      ascii_q    <= 8'h00;
      gap_q      <= '0;
      armed_q    <= 1'b0;
      start_q    <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      state_q    <= state_d;
      char_q     <= char_d;
      ascii_q    <= ascii_d;
      gap_q      <= gap_d;
      armed_q    <= armed_d;
      start_q    <= start_d;
    end
  end

endmodule

// File: tb/tb_morse_message_sequencer.sv
// Bench for morse_message_sequencer: a small generator model answers start
// strobes, and expected characters and cycle timing come from a timing model
// built from the sequencing rules (IDLE pop, LOAD, START, gaps in Morse units).
module tb_morse_message_sequencer;
  localparam int DEPTH = 4;
  localparam int MC    = 2;
  localparam int CU    = 3;
  localparam int WU    = 7;
  localparam int CG    = CU * MC;
  localparam int WG    = (WU - CU) * MC;
  localparam int CNTW  = $clog2(DEPTH) + 1;
  localparam int BOUND = 400;
  localparam int POOLN = 12;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic [7:0]      rx_data = 8'h00;
  logic            rx_valid = 1'b0;
  logic [7:0]      gen_ascii;
  logic            gen_start;
  logic            gen_done;
  logic            busy, full, ovf;
  logic [CNTW-1:0] cnt;

  int errors = 0;
  int checks = 0;
  int cyc;

  // generator model controls
  bit g_hold  = 1'b0;
  bit g_stall = 1'b0;
  int g_len   = 2;
  int g_drop  = 0;
  int gphase, gcnt;

  // monitor records
  int         st_cyc_q[$];
  logic [7:0] st_chr_q[$];
  int         rise_q[$];
  int         dbl_cnt = 0;
  int         rst_start_cnt = 0;
  logic       prev_start = 1'b0;
  logic       prev_done = 1'b0;

  logic [7:0] burst[$];
  logic [7:0] pool [POOLN] = '{8'h41, 8'h61, 8'h7A, 8'h5A, 8'h60, 8'h7B,
                               8'h31, 8'h20, 8'h0A, 8'h0D, 8'h3F, 8'hE9};

  morse_message_sequencer #(
    .FIFO_DEPTH(DEPTH), .MORSE_CYCLES(MC), .CHAR_GAP_UNITS(CU), .WORD_GAP_UNITS(WU)
  ) dut (
    .clk_i(clk), .reset_i(rst), .rx_data_i(rx_data), .rx_valid_i(rx_valid),
    .gen_ascii_o(gen_ascii), .gen_start_o(gen_start), .gen_done_i(gen_done),
    .busy_o(busy), .full_o(full), .overflow_o(ovf), .fifo_count_o(cnt)
  );

  always #5 clk = ~clk;

  // Generator model: after start, optionally keeps an old done high for g_drop
  // cycles, drops it, then raises done after g_len cycles (pulse or held level).
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rst) begin
      gen_done <= 1'b0; gphase <= 0; gcnt <= 0;
    end else if (gen_start) begin
      gphase <= 1; gcnt <= g_drop;
      if (!g_hold) gen_done <= 1'b0;
    end else begin
      case (gphase)
        1: if (gcnt == 0) begin gen_done <= 1'b0; gphase <= 2; gcnt <= g_len; end
           else gcnt <= gcnt - 1;
        2: if (!g_stall) begin
             if (gcnt == 0) begin gen_done <= 1'b1; gphase <= g_hold ? 0 : 3; end
             else gcnt <= gcnt - 1;
           end
        3: begin gen_done <= 1'b0; gphase <= 0; end
        default: ;
      endcase
    end
  end

  // Record start strobes, done rising edges and start-pulse anomalies.
  always @(negedge clk) begin
    if (gen_start) begin st_cyc_q.push_back(cyc); st_chr_q.push_back(gen_ascii); end
    if (gen_start && prev_start) dbl_cnt <= dbl_cnt + 1;
    if (gen_start && rst) rst_start_cnt <= rst_start_cnt + 1;
    if (gen_done && !prev_done) rise_q.push_back(cyc);
    prev_start <= gen_start;
    prev_done  <= gen_done;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, observed no finish, required finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_byte(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    tick();
  endtask

  function automatic logic [7:0] norm(input logic [7:0] b);
    return (b >= 8'h61 && b <= 8'h7A) ? b - 8'h20 : b;
  endfunction

  function automatic bit is_sep(input logic [7:0] b);
    return (b == 8'h20) || (b == 8'h0A) || (b == 8'h0D);
  endfunction

  task automatic wait_idle(input string nm);
    int to;
    to = 0;
    while (busy && to < BOUND) begin tick(); to++; end
    chk({nm, "_drain"}, int'(to < BOUND), 1);
  endtask

  // Write the burst back-to-back into an idle, empty sequencer and compare
  // every start (character and cycle) and the final return to idle.
  task automatic run_burst(input string nm);
    int sb, rb, db, w0, r, ci, n;
    bit rvalid;
    logic [7:0] exp_chr[$];
    int exp_cyc[$];
    sb = st_cyc_q.size(); rb = rise_q.size(); db = dbl_cnt; w0 = 0;
    foreach (burst[i]) begin
      write_byte(burst[i]);
      if (i == 0) w0 = cyc;
    end
    wait_idle(nm);
    // r: edge after which the FSM sits in IDLE with the next byte available
    r = w0; ci = 0; rvalid = 1'b1;
    foreach (burst[i]) begin
      if (is_sep(burst[i])) r += 2 + WG;
      else begin
        exp_chr.push_back(norm(burst[i]));
        exp_cyc.push_back(r + 2);
        if (rb + ci < rise_q.size()) r = rise_q[rb + ci] + 1 + CG;
        else rvalid = 1'b0;
        ci++;
      end
    end
    n = st_cyc_q.size() - sb;
    chk({nm, "_nstart"}, n, exp_chr.size());
    chk({nm, "_nrise"}, rise_q.size() - rb, ci);
    for (int i = 0; i < exp_chr.size() && i < n; i++) begin
      chk($sformatf("%s_chr%0d", nm, i), int'(st_chr_q[sb + i]), int'(exp_chr[i]));
      chk($sformatf("%s_cyc%0d", nm, i), st_cyc_q[sb + i], exp_cyc[i]);
    end
    if (rvalid) chk({nm, "_idle_cyc"}, cyc, r);
    chk({nm, "_cnt0"}, int'(cnt), 0);
    chk({nm, "_single_pulse"}, dbl_cnt - db, 0);
    if (exp_chr.size() > 0) chk({nm, "_ascii_hold"}, int'(gen_ascii), int'(exp_chr[exp_chr.size() - 1]));
  endtask

  initial begin
    int sb, rb, d, to, n;
    #1 rst = 1'b1;
    #1;
    chk("rst_start", int'(gen_start), 0);
    chk("rst_ascii", int'(gen_ascii), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_full", int'(full), 0);
    chk("rst_ovf", int'(ovf), 0);
    chk("rst_cnt", int'(cnt), 0);
    repeat (3) tick();
    rst = 1'b0;
    tick();

    // single characters, pulse-style done
    burst.delete(); burst.push_back(8'h41); run_burst("A");
    burst.delete(); burst.push_back(8'h61); run_burst("lower_a");
    burst.delete(); burst.push_back(8'h31); run_burst("digit1");
    // word separator between two characters
    burst.delete(); burst.push_back(8'h41); burst.push_back(8'h20); burst.push_back(8'h42);
    run_burst("A_sp_B");
    // consecutive separators accumulate
    burst.delete(); burst.push_back(8'h45); burst.push_back(8'h0D); burst.push_back(8'h0A);
    burst.push_back(8'h54); run_burst("E_crlf_T");

    // done held high until a while after the next start
    g_hold = 1'b1; g_drop = 2; g_len = 3;
    burst.delete(); burst.push_back(8'h45); burst.push_back(8'h65); run_burst("hold_EE");
    g_hold = 1'b0; g_drop = 0;
    do_reset();

    // randomized bursts (at most DEPTH+1 bytes so nothing is dropped)
    for (int b = 0; b < 8; b++) begin
      burst.delete();
      n = $urandom_range(1, DEPTH + 1);
      for (int i = 0; i < n; i++) begin
        if ($urandom_range(0, 3) == 0) burst.push_back(8'($urandom_range(0, 255)));
        else burst.push_back(pool[$urandom_range(0, POOLN - 1)]);
      end
      g_len = $urandom_range(0, 4);
      run_burst($sformatf("rnd%0d", b));
    end

    // overflow with the generator stalled
    do_reset();
    g_stall = 1'b1; g_len = 3;
    sb = st_cyc_q.size();
    for (int i = 0; i < 5; i++) write_byte(8'h61 + 8'(i));
    chk("ovf_full5", int'(full), 1);
    chk("ovf_cnt5", int'(cnt), DEPTH);
    chk("ovf_flag5", int'(ovf), 0);
    write_byte(8'h66);
    chk("ovf_flag6", int'(ovf), 1);
    chk("ovf_cnt6", int'(cnt), DEPTH);
    rb = rise_q.size();
    g_stall = 1'b0;
    // push into a full FIFO on the pop edge: dropped
    to = 0;
    while (rise_q.size() <= rb && to < BOUND) begin tick(); to++; end
    chk("ovf_rise1", int'(to < BOUND), 1);
    if (to < BOUND) begin
      d = rise_q[rb] + 1;
      while (cyc < d + CG) tick();
      chk("ovf_full_before_pop", int'(full), 1);
      write_byte(8'h78);
      chk("ovf_full_pop_cnt", int'(cnt), DEPTH - 1);
      chk("ovf_full_pop_full", int'(full), 0);
    end
    // push on the next pop edge with room: count unchanged
    to = 0;
    while (rise_q.size() <= rb + 1 && to < BOUND) begin tick(); to++; end
    chk("ovf_rise2", int'(to < BOUND), 1);
    if (to < BOUND) begin
      d = rise_q[rb + 1] + 1;
      while (cyc < d + CG) tick();
      write_byte(8'h79);
      chk("ovf_pushpop_cnt", int'(cnt), DEPTH - 1);
    end
    wait_idle("ovf");
    chk("ovf_nstart", st_cyc_q.size() - sb, 6);
    for (int i = 0; i < 6 && sb + i < st_chr_q.size(); i++)
      chk($sformatf("ovf_chr%0d", i), int'(st_chr_q[sb + i]), (i < 5) ? 8'h41 + i : 8'h59);
    chk("ovf_sticky", int'(ovf), 1);

    // asynchronous reset in the middle of WAIT_DONE with 3 bytes queued
    do_reset();
    chk("post_rst_ovf", int'(ovf), 0);
    g_stall = 1'b1; g_len = 2;
    write_byte(8'h48); write_byte(8'h49); write_byte(8'h4A); write_byte(8'h4B);
    repeat (3) tick();
    chk("mid_cnt", int'(cnt), 3);
    chk("mid_busy", int'(busy), 1);
    #3 rst = 1'b1;
    #1;
    chk("mid_rst_start", int'(gen_start), 0);
    chk("mid_rst_ascii", int'(gen_ascii), 0);
    chk("mid_rst_busy", int'(busy), 0);
    chk("mid_rst_cnt", int'(cnt), 0);
    chk("mid_rst_full", int'(full), 0);
    repeat (4) tick();
    rst = 1'b0;
    g_stall = 1'b0;
    sb = st_cyc_q.size();
    repeat (40) tick();
    chk("mid_no_start", st_cyc_q.size() - sb, 0);
    chk("mid_idle", int'(busy), 0);
    chk("mid_no_start_in_rst", rst_start_cnt, 0);
    burst.delete(); burst.push_back(8'h71); run_burst("after_rst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
